softmax_norm: RTL and testbench
===============================

SOFTMAX_NORM -- requirements
Module: softmax_norm

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the maximum number of Q16.16 exp values per group (2..16).
REQ-002 SHALL have port clk  input  1  the single clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_data/in_last valid.
REQ-005 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port in_data  input  32  unsigned Q16.16 exp value from the exp stage.
REQ-007 SHALL have port in_last  input  1  final element of the group.
REQ-008 SHALL have port out_valid  output  1  out_data/out_last valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts output.
REQ-010 SHALL have port out_data  output  32  Q16.16 normalised value in_data[k]/sum.
REQ-011 SHALL have port out_last  output  1  final normalised element of the group.
REQ-012 SHALL have port busy  output  1  high in any state other than COLLECT.

Function
REQ-013 SHALL implement states COLLECT, DIV, OUT; in_ready = 1 only in COLLECT.
REQ-014 SHALL, in COLLECT on in_valid&&in_ready, store in_data to buf[count], add it to 32-bit sum, and increment count.
REQ-015 SHALL leave COLLECT for DIV with idx=0 when the accepted element has in_last=1 or is element DEPTH (count==DEPTH-1); the DEPTH-th element is treated as last.
REQ-016 SHALL, in DIV, compute q = ({buf[idx],16'h0}) / {16'h0,sum} as an unsigned 48-bit restoring division, one quotient bit per cycle, exactly 48 cycles per element.
REQ-017 SHALL, at the end of the 48th DIV cycle, register out_data = q[31:0], out_last = (idx==count-1), assert out_valid, and enter OUT.
REQ-018 SHALL, when sum==0, produce out_data = 0 for every element of the group (no divide performed, 48-cycle timing unchanged).
REQ-019 SHALL hold out_data/out_last/out_valid stable in OUT until out_ready is high.
REQ-020 SHALL, on out_valid&&out_ready, deassert out_valid, then increment idx and return to DIV, or, if out_last, clear count and sum and return to COLLECT.
REQ-021 SHALL ignore in_valid/in_data/in_last outside COLLECT.
REQ-022 SHALL give a first-element latency of 48 cycles from the accepting edge of the last input to the edge asserting out_valid, and 49 cycles between element handshakes with out_ready held high.

Reset
REQ-023 SHALL, on rst high, asynchronously set state=COLLECT, count=0, idx=0, sum=0, out_valid=0, out_data=0, out_last=0; in_ready=1 and busy=0 after reset.
REQ-024 SHALL discard any partially collected or partially output group when rst asserts mid-operation.

Configuration
REQ-025 SHALL compile saturation logic only when SOFTMAX_SAT_EN is defined: sum saturates at 32'hFFFF_FFFF instead of wrapping, and any q greater than 32'h0001_0000 outputs 32'h0001_0000.
REQ-026 SHALL, without SOFTMAX_SAT_EN, wrap sum modulo 2^32 and output q[31:0] unclamped.

Verification
REQ-027 SHALL verify: inputs 0x00010000, 0x00010000 (last on 2nd), out_ready=1 -> outputs 0x00008000, 0x00008000, out_last on 2nd only, first out_valid 48 cycles after the last accept.
REQ-028 SHALL verify: single input 0x0002B7E1 with in_last -> single output 0x00010000 with out_last=1.
REQ-029 SHALL verify: 9 consecutive valid inputs of 0x00010000, no in_last, DEPTH=8 -> 8 accepted, in_ready low for the 9th until the 8th output handshakes, 8 outputs of 0x00002000, out_last on the 8th.
REQ-030 SHALL verify: three zero inputs with last on the 3rd -> three outputs 0x00000000, out_last on the 3rd.
REQ-031 SHALL verify: out_ready held low 10 cycles during OUT -> out_data/out_last constant, out_valid high throughout, no extra element emitted.
REQ-032 SHALL verify: rst pulsed during DIV of a 4-element group -> all outputs at reset values within the same cycle; next group 0x00030000, 0x00010000 (last) -> 0x0000C000, 0x00004000.

Source files
------------

// File: rtl/softmax_norm.sv
// Softmax normaliser: collects a group of Q16.16 exp values, then emits each
// value divided by the group sum. Define SOFTMAX_SAT_EN for saturating sum and a result clamp at 1.0.
module softmax_norm #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_DIV     = 2'd1,
        S_OUT     = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] count_q;
    logic [IW-1:0] idx_q;
    logic [31:0]   sum_q;
    logic [5:0]    bit_q;
    logic [31:0]   rem_q;
    logic [30:0]   quo_q;
    logic [47:0]   dvd_q;
    logic          out_valid_q;
    logic [31:0]   out_data_q;
    logic          out_last_q;
    logic [31:0]   buf_q [DEPTH];

    logic [47:0]   dvd_cur_s;
    logic [31:0]   rem_cur_s;
    logic [30:0]   quo_cur_s;
    logic [32:0]   rem_sh_s;
    logic          div_ge_s;
    logic [31:0]   rem_d;
    logic [31:0]   quo_d;
    logic [47:0]   dvd_d;
    logic [31:0]   result_s;

`ifdef SOFTMAX_SAT_EN
    logic          ovf_q;
    logic          ovf_cur_s;
    logic          ovf_d;
`endif

    function automatic logic [31:0] add_sum(input logic [31:0] a, input logic [31:0] b);
`ifdef SOFTMAX_SAT_EN
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return s[31:0];
        end
`else
        return a + b;
`endif
    endfunction

    assign in_ready  = (state_q == S_COLLECT);
    assign busy      = (state_q != S_COLLECT);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    // One restoring-division step; step 0 loads the dividend straight from the buffer.
    always_comb begin
        dvd_cur_s = dvd_q;
        rem_cur_s = rem_q;
        quo_cur_s = quo_q;
        if (bit_q == 6'd0) begin
            dvd_cur_s = {buf_q[idx_q], 16'h0000};
            rem_cur_s = 32'd0;
            quo_cur_s = 31'd0;
        end else begin
            dvd_cur_s = dvd_q;
            rem_cur_s = rem_q;
            quo_cur_s = quo_q;
        end
        rem_sh_s = {rem_cur_s, dvd_cur_s[47]};
        div_ge_s = (rem_sh_s >= {1'b0, sum_q});
        if (div_ge_s) begin
            rem_d = rem_sh_s[31:0] - sum_q;
        end else begin
            rem_d = rem_sh_s[31:0];
        end
        quo_d = {quo_cur_s, div_ge_s};
        dvd_d = {dvd_cur_s[46:0], 1'b0};
    end

`ifdef SOFTMAX_SAT_EN
    // Quotient bits that shift past bit 31 are remembered so the clamp sees the full 48-bit value.
    always_comb begin
        if (bit_q == 6'd0) begin
            ovf_cur_s = 1'b0;
        end else begin
            ovf_cur_s = ovf_q;
        end
        ovf_d = ovf_cur_s | quo_d[31];
        if (sum_q == 32'd0) begin
            result_s = 32'd0;
        end else if (ovf_cur_s || (quo_d > 32'h0001_0000)) begin
            result_s = 32'h0001_0000;
        end else begin
            result_s = quo_d;
        end
    end

    // Overflow tracker for the clamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == S_DIV) begin
            ovf_q <= ovf_d;
        end else begin
            ovf_q <= ovf_q;
        end
    end
`else
    // Final quotient selection; a zero sum yields zero without a real divide.
    always_comb begin
        if (sum_q == 32'd0) begin
            result_s = 32'd0;
        end else begin
            result_s = quo_d;
        end
    end
`endif

    // Element storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if ((state_q == S_COLLECT) && in_valid) begin
            buf_q[count_q[IW-1:0]] <= in_data;
        end
    end

    // Main control FSM with registered output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_COLLECT;
            count_q     <= '0;
            idx_q       <= '0;
            sum_q       <= 32'd0;
            bit_q       <= 6'd0;
            rem_q       <= 32'd0;
            quo_q       <= 31'd0;
            dvd_q       <= 48'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (in_valid) begin
                        count_q <= count_q + CW'(1);
                        sum_q   <= add_sum(sum_q, in_data);
                        if (in_last || (count_q == CW'(DEPTH - 1))) begin
                            state_q <= S_DIV;
                            idx_q   <= '0;
                            bit_q   <= 6'd0;
                        end
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d[30:0];
                    dvd_q <= dvd_d;
                    if (bit_q == 6'd47) begin
                        bit_q       <= 6'd0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= result_s;
                        out_last_q  <= (CW'(idx_q) == (count_q - CW'(1)));
                        state_q     <= S_OUT;
                    end else begin
                        bit_q <= bit_q + 6'd1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            count_q <= '0;
                            sum_q   <= 32'd0;
                            state_q <= S_COLLECT;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= S_DIV;
                        end
                    end
                end
                default: begin
                    state_q <= S_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_norm.sv
// Directed self-checking bench for softmax_norm (DEPTH=8) with hand-computed quotients.
module tb_softmax_norm;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    int n_total;
    int n_bad;
    int cyc;

    logic [31:0] q_data [$];
    logic        q_last [$];
    int          q_cyc  [$];

    softmax_norm #(.DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output scoreboard capture on every handshake.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total = n_total + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int t;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        t = 0;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'd0;
    endtask

    task automatic wait_outs(input int n);
        int t;
        t = 0;
        while (q_data.size() < n && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 3000) chk("outs_timeout", 32'(q_data.size()), 32'(n));
        @(negedge clk);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_q();
    endtask

    initial begin
        int n;
        logic [31:0] held_d;
        logic        held_l;
        n_total   = 0;
        n_bad     = 0;
        cyc       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);

        // Two equal values: each is one half; latency and handshake spacing.
        clear_q();
        send(32'h0001_0000, 1'b0);
        send(32'h0001_0000, 1'b1);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (out_valid) break;
            if (n == 0) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(posedge clk);
            n++;
        end
        chk("t1_latency", 32'(n), 32'd48);
        wait_outs(2);
        chk("t1_d0", q_data[0], 32'h0000_8000);
        chk("t1_l0", 32'(q_last[0]), 32'd0);
        chk("t1_d1", q_data[1], 32'h0000_8000);
        chk("t1_l1", 32'(q_last[1]), 32'd1);
        chk("t1_gap", 32'(q_cyc[1] - q_cyc[0]), 32'd49);

        // Single element normalises to exactly 1.0.
        clear_q();
        send(32'h0002_B7E1, 1'b1);
        idle();
        wait_outs(1);
        chk("t2_d0", q_data[0], 32'h0001_0000);
        chk("t2_l0", 32'(q_last[0]), 32'd1);

        // Nine inputs without last: the eighth closes the group.
        clear_q();
        for (int i = 0; i < 8; i++) send(32'h0001_0000, 1'b0);
        @(negedge clk);
        chk("t3_rdy_low", 32'(in_ready), 32'd0);
        n = 0;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t3_outs_at_ready", 32'(q_data.size()), 32'd8);
        @(posedge clk);
        idle();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_d%0d", i), q_data[i], 32'h0000_2000);
            chk($sformatf("t3_l%0d", i), 32'(q_last[i]), (i == 7) ? 32'd1 : 32'd0);
        end
        pulse_rst();

        // Zero sum gives zero outputs.
        send(32'd0, 1'b0);
        send(32'd0, 1'b0);
        send(32'd0, 1'b1);
        idle();
        wait_outs(3);
        chk("t4_d0", q_data[0], 32'd0);
        chk("t4_d1", q_data[1], 32'd0);
        chk("t4_d2", q_data[2], 32'd0);
        chk("t4_l1", 32'(q_last[1]), 32'd0);
        chk("t4_l2", 32'(q_last[2]), 32'd1);

        // Backpressure: output held stable while out_ready is low.
        clear_q();
        out_ready = 1'b0;
        send(32'h0001_0000, 1'b0);
        send(32'h0003_0000, 1'b1);
        idle();
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        held_d = out_data;
        held_l = out_last;
        chk("t5_first", held_d, 32'h0000_4000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_hold_v", 32'(out_valid), 32'd1);
            chk("t5_hold_d", out_data, held_d);
            chk("t5_hold_l", 32'(out_last), 32'(held_l));
        end
        out_ready = 1'b1;
        wait_outs(2);
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("t5_count", 32'(q_data.size()), 32'd2);
        chk("t5_d1", q_data[1], 32'h0000_C000);
        chk("t5_l1", 32'(q_last[1]), 32'd1);

        // Reset in the middle of a group's division.
        clear_q();
        for (int i = 0; i < 4; i++) send(32'h0001_0000, (i == 3) ? 1'b1 : 1'b0);
        idle();
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t6_busy_div", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_data", out_data, 32'd0);
        chk("t6_rst_last", 32'(out_last), 32'd0);
        chk("t6_rst_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_q();
        send(32'h0003_0000, 1'b0);
        send(32'h0001_0000, 1'b1);
        idle();
        wait_outs(2);
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("t6_count", 32'(q_data.size()), 32'd2);
        chk("t6_d0", q_data[0], 32'h0000_C000);
        chk("t6_d1", q_data[1], 32'h0000_4000);
        chk("t6_l1", 32'(q_last[1]), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
